// File: rtl/ifmap_row_fetch_pkg.sv
// Shared widths, FSM encoding and row payload for the ifmap row fetcher.
package ifmap_row_fetch_pkg;

  localparam int unsigned WORD_SIZE = 128;
  localparam int unsigned CODE_W    = 4;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned PAD_W     = 2;
  localparam int unsigned TOTAL_W   = 10;

  typedef enum logic [2:0] {
    FETCH_IDLE  = 3'd0,
    FETCH_TOP   = 3'd1,
    FETCH_FETCH = 3'd2,
    FETCH_BOT   = 3'd3,
    FETCH_DRAIN = 3'd4
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_SIZE-1:0] data;
    logic [CODE_W-1:0]    pad;
    logic [CODE_W-1:0]    col;
    logic                 last;
  } row_t;

endpackage

// File: rtl/ifmap_row_fetch_row_fifo2.sv
// Two-entry in-order row buffer; the head entry is a register that drives the outputs directly.
module row_fifo2
  import ifmap_row_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  row_t       wr_row,
  input  logic       pop,
  output row_t       rd_row,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  row_t       head_q;
  row_t       tail_q;
  logic [1:0] count_q;
  logic       pop_ok;
  logic       push_ok;

  assign pop_ok  = pop && (count_q != 2'd0);
  assign push_ok = push && ((count_q != 2'd2) || pop_ok);

  // Head/tail shift structure: a pop promotes the tail into the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      unique case ({push_ok, pop_ok})
        2'b11: begin
          if (count_q == 2'd1) begin
            head_q <= wr_row;
          end else begin
            head_q <= tail_q;
            tail_q <= wr_row;
          end
        end
        2'b01: begin
          if (count_q == 2'd2) head_q <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) head_q <= wr_row;
          else                 tail_q <= wr_row;
          count_q <= count_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign rd_row = head_q;
  assign full   = (count_q == 2'd2);
  assign empty  = (count_q == 2'd0);
  assign count  = count_q;

endmodule

// File: rtl/ifmap_row_fetch.sv
// Streams one feature-map tile out of the unified buffer SRAM, inserting the
// vertical zero-padding rows and tagging every row with its padding/column codes.
module ifmap_row_fetch
  import ifmap_row_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W-1:0]    row_stride,
  input  logic [CNT_W-1:0]     num_rows,
  input  logic [PAD_W-1:0]     pad_top,
  input  logic [PAD_W-1:0]     pad_bottom,
  input  logic [CODE_W-1:0]    pad_ctrl,
  input  logic [CODE_W-1:0]    col_size,
  output logic                 sram_re,
  output logic [ADDR_W-1:0]    sram_addr,
  input  logic [WORD_SIZE-1:0] sram_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_data,
  output logic [CODE_W-1:0]    out_pad,
  output logic [CODE_W-1:0]    out_col,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  fetch_state_e state_q, state_d;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TOTAL_W-1:0] rem_q;
  logic [TOTAL_W-1:0] total_in;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  stride_q;
  logic [CNT_W-1:0]   num_rows_q;
  logic [PAD_W-1:0]   pad_bot_q;
  logic [CODE_W-1:0]  pad_code_q;
  logic [CODE_W-1:0]  col_code_q;
  logic               tile_empty_q;
  logic               rd_pend_q;
  logic               rd_last_q;
  logic               busy_q;
  logic               done_q;
  logic               done_d;

  logic               start_acc;
  logic               issue_zero;
  logic               issue_rd;
  logic               last_flag;
  logic               pop;
  logic               can_issue;
  logic [1:0]         slots_used;

  row_t               fifo_wr;
  row_t               fifo_rd;
  logic               fifo_push;
  logic               fifo_full;
  logic               fifo_empty;
  logic [1:0]         fifo_count;

  assign total_in  = TOTAL_W'(pad_top) + TOTAL_W'(num_rows) + TOTAL_W'(pad_bottom);
  assign start_acc = start && (state_q == FETCH_IDLE);
  assign last_flag = (rem_q == TOTAL_W'(1));
  assign pop       = !fifo_empty && out_ready;

  // A full buffer implies no read in flight; otherwise count buffered rows plus the pending read.
  assign slots_used = fifo_full ? 2'd2 : (fifo_count + 2'(rd_pend_q));
  assign can_issue  = (slots_used < 2'd2) || ((slots_used == 2'd2) && pop);

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    issue_zero = 1'b0;
    issue_rd   = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      FETCH_IDLE: begin
        if (start) begin
          if (total_in == '0) begin
            state_d = FETCH_DRAIN;
          end else if (pad_top != '0) begin
            state_d = FETCH_TOP;
            cnt_d   = CNT_W'(pad_top);
          end else if (num_rows != '0) begin
            state_d = FETCH_FETCH;
            cnt_d   = num_rows;
          end else begin
            state_d = FETCH_BOT;
            cnt_d   = CNT_W'(pad_bottom);
          end
        end
      end
      // Zero rows wait for any in-flight read so they cannot overtake it.
      FETCH_TOP: begin
        if (can_issue && !rd_pend_q) begin
          issue_zero = 1'b1;
          cnt_d      = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            if (num_rows_q != '0) begin
              state_d = FETCH_FETCH;
              cnt_d   = num_rows_q;
            end else if (pad_bot_q != '0) begin
              state_d = FETCH_BOT;
              cnt_d   = CNT_W'(pad_bot_q);
            end else begin
              state_d = FETCH_DRAIN;
            end
          end
        end
      end
      FETCH_FETCH: begin
        if (can_issue) begin
          issue_rd = 1'b1;
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            if (pad_bot_q != '0) begin
              state_d = FETCH_BOT;
              cnt_d   = CNT_W'(pad_bot_q);
            end else begin
              state_d = FETCH_DRAIN;
            end
          end
        end
      end
      FETCH_BOT: begin
        if (can_issue && !rd_pend_q) begin
          issue_zero = 1'b1;
          cnt_d      = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = FETCH_DRAIN;
        end
      end
      FETCH_DRAIN: begin
        if ((pop && fifo_rd.last) || (tile_empty_q && fifo_empty && !rd_pend_q)) begin
          state_d = FETCH_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  // Config latch, address accumulator, row bookkeeping and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      rem_q        <= '0;
      addr_q       <= '0;
      stride_q     <= '0;
      num_rows_q   <= '0;
      pad_bot_q    <= '0;
      pad_code_q   <= '0;
      col_code_q   <= '0;
      tile_empty_q <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_last_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rd_pend_q <= issue_rd;
      rd_last_q <= last_flag;
      busy_q    <= (state_d != FETCH_IDLE);
      done_q    <= done_d;
      if (start_acc) begin
        addr_q       <= base_addr;
        stride_q     <= row_stride;
        num_rows_q   <= num_rows;
        pad_bot_q    <= pad_bottom;
        pad_code_q   <= pad_ctrl;
        col_code_q   <= col_size;
        rem_q        <= total_in;
        tile_empty_q <= (total_in == '0);
      end else begin
        if (issue_rd)              addr_q <= addr_q + stride_q;
        if (issue_rd || issue_zero) rem_q <= rem_q - TOTAL_W'(1);
      end
    end
  end

  // Returning SRAM data takes the write port; zero rows only issue when it is free.
  always_comb begin
    fifo_wr     = '0;
    fifo_wr.pad = pad_code_q;
    fifo_wr.col = col_code_q;
    if (rd_pend_q) begin
      fifo_wr.data = sram_rdata;
      fifo_wr.last = rd_last_q;
    end else begin
      fifo_wr.last = last_flag;
    end
  end

  assign fifo_push = rd_pend_q || issue_zero;

  row_fifo2 u_row_fifo2 (
    .clk    (clk),
    .rst    (rst),
    .push   (fifo_push),
    .wr_row (fifo_wr),
    .pop    (out_ready),
    .rd_row (fifo_rd),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign sram_re   = issue_rd;
  assign sram_addr = addr_q;
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_rd.data;
  assign out_pad   = fifo_rd.pad;
  assign out_col   = fifo_rd.col;
  assign out_last  = fifo_rd.last;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ifmap_row_fetch.sv
// Scoreboard bench for ifmap_row_fetch: a tile model fills expected-row and
// expected-address queues at start; a negedge monitor pops and compares.
module tb_ifmap_row_fetch;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   pad;
    logic [3:0]   col;
    logic         last;
  } exp_row_t;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] row_stride;
  logic [7:0]        num_rows;
  logic [1:0]        pad_top;
  logic [1:0]        pad_bottom;
  logic [3:0]        pad_ctrl;
  logic [3:0]        col_size;
  logic              sram_re;
  logic [ADDR_W-1:0] sram_addr;
  logic [127:0]      sram_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [127:0]      out_data;
  logic [3:0]        out_pad;
  logic [3:0]        out_col;
  logic              out_last;
  logic              busy;
  logic              done;

  logic [127:0]      mem [DEPTH];
  exp_row_t          exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];

  int errors;
  int checks;
  int done_cnt;
  int hs_cnt;
  int ready_mode;

  ifmap_row_fetch #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .row_stride (row_stride),
    .num_rows   (num_rows),
    .pad_top    (pad_top),
    .pad_bottom (pad_bottom),
    .pad_ctrl   (pad_ctrl),
    .col_size   (col_size),
    .sram_re    (sram_re),
    .sram_addr  (sram_addr),
    .sram_rdata (sram_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_pad    (out_pad),
    .out_col    (out_col),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency SRAM
  always @(posedge clk) begin
    if (sram_re) sram_rdata <= mem[sram_addr];
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Downstream ready: always, fixed 1,0,0,1,0,1 pattern, or random
  initial begin
    logic [5:0] pat;
    int pi;
    pat = 6'b101001;
    pi = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = pat[pi];
          pi = (pi + 1) % 6;
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    logic     stalled;
    logic     done_pend;
    exp_row_t held;
    exp_row_t e;
    stalled   = 1'b0;
    done_pend = 1'b0;
    held      = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled   = 1'b0;
        done_pend = 1'b0;
      end else begin
        if (done_pend) begin
          chk("done_after_last", 128'(done), 128'(1));
          chk("busy_fall_with_done", 128'(busy), 128'(0));
          done_pend = 1'b0;
        end
        if (done) done_cnt++;
        if (sram_re) begin
          if (exp_addr_q.size() == 0) chk("unexpected_read", 128'(1), 128'(0));
          else chk("sram_addr", 128'(sram_addr), 128'(exp_addr_q.pop_front()));
        end
        if (stalled) begin
          chk("hold_valid", 128'(out_valid), 128'(1));
          chk("hold_row", 128'({out_data, out_pad, out_col, out_last}), 128'(held));
        end
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk("spurious_row", 128'(1), 128'(0));
          end else if (out_ready) begin
            e = exp_q.pop_front();
            chk("row_data", out_data, e.data);
            chk("row_pad", 128'(out_pad), 128'(e.pad));
            chk("row_col", 128'(out_col), 128'(e.col));
            chk("row_last", 128'(out_last), 128'(e.last));
            hs_cnt++;
            if (e.last) done_pend = 1'b1;
          end
        end
        stalled = out_valid && !out_ready;
        held    = {out_data, out_pad, out_col, out_last};
      end
    end
  end

  task automatic push_row(input logic [127:0] d, input logic [3:0] pc, input logic [3:0] cc,
                          input logic l);
    exp_row_t e;
    e.data = d;
    e.pad  = pc;
    e.col  = cc;
    e.last = l;
    exp_q.push_back(e);
  endtask

  // Model the tile from its config, then pulse start (returns early in cycle 1)
  task automatic start_tile(input logic [9:0] b, input logic [9:0] s, input logic [7:0] n,
                            input logic [1:0] pt, input logic [1:0] pb,
                            input logic [3:0] pc, input logic [3:0] cc);
    int t;
    int k;
    int a;
    t = int'(pt) + int'(n) + int'(pb);
    k = 0;
    for (int i = 0; i < int'(pt); i++) begin
      push_row('0, pc, cc, k == t - 1);
      k++;
    end
    for (int i = 0; i < int'(n); i++) begin
      a = (int'(b) + i * int'(s)) % DEPTH;
      exp_addr_q.push_back(10'(a));
      push_row(mem[a], pc, cc, k == t - 1);
      k++;
    end
    for (int i = 0; i < int'(pb); i++) begin
      push_row('0, pc, cc, k == t - 1);
      k++;
    end
    @(posedge clk);
    #1;
    base_addr  = b;
    row_stride = s;
    num_rows   = n;
    pad_top    = pt;
    pad_bottom = pb;
    pad_ctrl   = pc;
    col_size   = cc;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    for (int n = 0; n < budget && done_cnt <= d0; n++) begin
      @(negedge clk);
      #1;
    end
    chk("done_seen", 128'(done_cnt > d0), 128'(1));
    repeat (3) @(negedge clk);
    #1;
    chk("single_done", 128'(done_cnt), 128'(d0 + 1));
    chk("rows_drained", 128'(exp_q.size()), 128'(0));
    chk("reads_drained", 128'(exp_addr_q.size()), 128'(0));
    chk("idle_after_tile", 128'(busy), 128'(0));
  endtask

  task automatic chk_reset_values();
    chk("rst_sram_re", 128'(sram_re), 128'(0));
    chk("rst_sram_addr", 128'(sram_addr), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", out_data, 128'(0));
    chk("rst_out_pad", 128'(out_pad), 128'(0));
    chk("rst_out_col", 128'(out_col), 128'(0));
    chk("rst_out_last", 128'(out_last), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
  endtask

  initial begin
    int d0;
    int h0;
    errors = 0;
    checks = 0;
    done_cnt = 0;
    hs_cnt = 0;
    ready_mode = 0;
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    row_stride = '0;
    num_rows = '0;
    pad_top = '0;
    pad_bottom = '0;
    pad_ctrl = '0;
    col_size = '0;
    sram_rdata = '0;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_values();

    // Basic tile with first-row timing
    d0 = done_cnt;
    start_tile(10'h010, 10'd4, 8'd3, 2'd1, 2'd1, 4'h5, 4'hA);
    @(negedge clk);
    chk("busy_cycle1", 128'(busy), 128'(1));
    chk("no_row_cycle1", 128'(out_valid), 128'(0));
    @(negedge clk);
    chk("zero_row_cycle2", 128'(out_valid), 128'(1));
    wait_done(d0, 200);

    // Same tile under backpressure
    ready_mode = 1;
    d0 = done_cnt;
    start_tile(10'h010, 10'd4, 8'd3, 2'd1, 2'd1, 4'h5, 4'hA);
    wait_done(d0, 300);

    // Empty tile
    ready_mode = 0;
    d0 = done_cnt;
    start_tile(10'h000, 10'd0, 8'd0, 2'd0, 2'd0, 4'h3, 4'h4);
    @(negedge clk);
    chk("empty_done_cycle1", 128'(done), 128'(0));
    chk("empty_busy_cycle1", 128'(busy), 128'(1));
    @(negedge clk);
    chk("empty_done_cycle2", 128'(done), 128'(1));
    chk("empty_busy_cycle2", 128'(busy), 128'(0));
    #1;
    wait_done(d0, 50);

    // Address wrap, SRAM row first at cycle 3
    d0 = done_cnt;
    start_tile(10'h3FE, 10'd1, 8'd3, 2'd0, 2'd0, 4'h1, 4'h2);
    @(negedge clk);
    chk("sram_row_cycle1", 128'(out_valid), 128'(0));
    @(negedge clk);
    chk("sram_row_cycle2", 128'(out_valid), 128'(0));
    @(negedge clk);
    chk("sram_row_cycle3", 128'(out_valid), 128'(1));
    wait_done(d0, 200);

    // Reset after the second handshake, then a fresh tile
    h0 = hs_cnt;
    start_tile(10'h020, 10'd2, 8'd6, 2'd2, 2'd1, 4'h7, 4'h9);
    for (int n = 0; n < 200 && hs_cnt < h0 + 2; n++) begin
      @(negedge clk);
      #1;
    end
    chk("two_handshakes", 128'(hs_cnt >= h0 + 2), 128'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    @(negedge clk);
    chk_reset_values();
    d0 = done_cnt;
    start_tile(10'h100, 10'd3, 8'd4, 2'd1, 2'd2, 4'hC, 4'h6);
    wait_done(d0, 200);

    // Start pulse and config change while busy are ignored
    ready_mode = 2;
    d0 = done_cnt;
    start_tile(10'h050, 10'd5, 8'd5, 2'd1, 2'd1, 4'h2, 4'hE);
    repeat (2) @(posedge clk);
    #1;
    base_addr  = 10'h2AA;
    row_stride = 10'd9;
    num_rows   = 8'd7;
    pad_top    = 2'd3;
    pad_bottom = 2'd3;
    pad_ctrl   = 4'hF;
    col_size   = 4'h1;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(d0, 400);

    // Random tiles under random or patterned backpressure
    for (int t = 0; t < 10; t++) begin
      ready_mode = (t % 3 == 0) ? 1 : 2;
      d0 = done_cnt;
      start_tile(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                 8'($urandom_range(0, 12)), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)));
      wait_done(d0, 600);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifmap_row_fetch.md
# ifmap_row_fetch

Sequences one feature-map tile out of the unified buffer SRAM, one 128-bit row per handshake, and feeds the zero-padding stage directly downstream. It inserts the vertical padding (all-zero top and bottom rows) itself. Horizontal padding and column masking are done by the zero-padding stage, so this block tags each row with the `pad_ctrl`/`col_size` codes. A 2-entry output buffer absorbs the SRAM's 1-cycle read latency under backpressure.

## Interface
- `ADDR_W`, 10, SRAM word-address width
- Data width is `` `WORD_SIZE `` (128) from `define.v`; not a parameter
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  1-cycle pulse; accepted only when `busy`=0
- `base_addr`  in  ADDR_W  address of first real row
- `row_stride`  in  ADDR_W  address increment between real rows
- `num_rows`  in  8  real rows to read
- `pad_top`, `pad_bottom`  in  2 each  zero rows before/after the real rows
- `pad_ctrl`  in  4  padding_size code forwarded with every row
- `col_size`  in  4  column-mask code forwarded with every row
- `sram_re`  out  1  read enable
- `sram_addr`  out  ADDR_W  read address
- `sram_rdata`  in  WORD_SIZE  valid the cycle after `sram_re`
- `out_valid`  out  1  row available
- `out_ready`  in  1  downstream accepts
- `out_data`  out  WORD_SIZE  row data
- `out_pad`  out  4  forwarded `pad_ctrl`
- `out_col`  out  4  forwarded `col_size`
- `out_last`  out  1  final row of tile
- `busy`  out  1  tile in progress
- `done`  out  1  1-cycle completion pulse

## Operation
- All config inputs are latched on the accepted `start`. Later changes have no effect until the next `start`.
- Row order: `pad_top` zero rows, then `num_rows` SRAM rows, then `pad_bottom` zero rows. Total T = sum of the three.
- Real row i reads address `base_addr + i*row_stride` mod 2^ADDR_W, computed by an accumulator, not a multiplier.
- FSM states:
  - IDLE -> TOP on `start`; goes to FETCH if `pad_top`=0.
  - TOP -> FETCH after the zero rows are issued; goes to BOT if `num_rows`=0.
  - FETCH -> BOT after the last read is issued.
  - BOT -> DRAIN after the zero rows are issued.
  - DRAIN -> IDLE when the buffer is empty and the final handshake is done.
  - If T=0: IDLE -> DRAIN, with `done` and no output rows.
- Issue rule: a row (zero write or SRAM read) issues only when buffer occupancy + reads in flight < 2. At most one row issues per cycle.
- Zero rows write `out_data`=0 into the buffer directly and still carry `pad_ctrl`/`col_size`.
- The buffer is an in-order FIFO. A zero row never overtakes an in-flight read.
- `out_last`=1 only on row T-1.
- `start` while `busy`=1 is ignored.

## Timing
- Reset values: `sram_re`=0, `sram_addr`=0, `out_valid`=0, `out_data`=0, `out_pad`=0, `out_col`=0, `out_last`=0, `busy`=0, `done`=0. The buffer is emptied and any in-flight read is discarded.
- `rst` mid-tile aborts it. The next cycle shows reset values, and a fresh `start` is accepted the cycle after `rst` deasserts.
- Starting from `start` in cycle 0:
  - `busy`=1 from cycle 1.
  - The first issue happens in cycle 1.
  - A zero row is at `out_valid` in cycle 2.
  - An SRAM row is at `out_valid` in cycle 3 (read in 1, captured in 2).
- With `out_ready` held at 1, the sustained rate is 1 row/cycle.
- Handshake: transfer on `out_valid & out_ready`. While `out_valid`=1 and `out_ready`=0, all `out_*` are held stable.
- A simultaneous pop and issue is allowed at occupancy+in-flight=2 only when the pop frees a slot in the same cycle.
- `done` pulses the cycle after the last handshake. `busy` falls in that same cycle.
- T=0: `done` in cycle 2.

## Structure
- `define.v` supplies `` `WORD_SIZE ``. FSM state encodings go there as `` `FETCH_IDLE ``…`` `FETCH_DRAIN `` macros.
- One sub-module: `row_fifo2`, a 2-entry FIFO of {WORD_SIZE data, 4 pad, 4 col, 1 last} with full/empty/count. Everything else is in this module.

## Test plan
- Basic tile: `base_addr`=0x010, `row_stride`=4, `num_rows`=3, `pad_top`=1, `pad_bottom`=1, `out_ready`=1. Expect 5 rows: 0, M[0x010], M[0x014], M[0x018], 0. `out_last` on row 5 only; `done` one cycle after; `out_pad`/`out_col` equal the latched codes.
- Backpressure: same tile with `out_ready` pattern 1,0,0,1,0,1… Expect no lost or duplicated rows, outputs stable while stalled, and never more than 2 rows buffered or in flight.
- Empty tile: all counts 0. Expect `done` in cycle 2 and `out_valid` never asserted.
- Address wrap: `ADDR_W`=10, `base_addr`=0x3FE, `row_stride`=1, `num_rows`=3. Expect `sram_addr` 0x3FE, 0x3FF, 0x000.
- Reset mid-tile: `rst` high after the 2nd handshake. Expect all reset values next cycle; a new tile afterwards runs correctly with no stale rows.
- `start` pulsed while busy, and config inputs changed mid-tile. Expect both ignored; the output matches the originally latched config.
